// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the seven-segment digit scanner
package seg_scan_pkg;
  typedef enum logic {BLANK, SHOW} state_t;
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W = 2;
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction
endpackage

// File: rtl/slot_timer.sv
// slot_timer: modulo-DIV slot counter with clear and enable, plus a wrap indicator
module slot_timer #(
  parameter int DIV = 10,
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en && (cnt == W'(DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit scan with a blanking gap at each digit change
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  blank,
  output logic                  frame_tick
);
  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > DIV - 2) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must lie in 1..DIV-2");
  end
  logic [CW-1:0]         cnt;
  logic                  wrap;
  state_t                state, state_nx;
  logic [SEL_W-1:0]      sel_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  logic                  tick_nx;
  slot_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!en),
    .en   (en),
    .cnt  (cnt),
    .wrap (wrap)
  );
  // Outputs are registered from next-state values so they line up with the cnt they describe.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= BLANK;
      sel        <= '0;
      an_n       <= '1;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      an_n       <= an_nx;
      blank      <= state_nx == BLANK;
      frame_tick <= tick_nx;
    end
  always_comb begin
    state_nx = (!en || wrap) ? BLANK : (cnt == CW'(BLANK_CYCLES - 1)) ? SHOW : state;
    sel_nx   = wrap ? sel + SEL_W'(1) : sel;
  end
  always_comb begin
    an_nx = '1;
    if (state_nx == SHOW) an_nx[sel_nx] = ~digit_mask[sel_nx];
    tick_nx = wrap && (sel == SEL_W'(NUM_DIGITS - 1));
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed digit scan controller for the Boolean Board 4-digit seven-segment display.
- Sits directly upstream of mux_4_1 and drives its sel input, so the mux routes one digit's data at a time.
- Also drives the active-low anode enables and inserts a blanking gap at every digit change. The gap stops ghosting while the mux output and the segment decode settle.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1_000, digit slot rate in Hz. Slot length DIV = CLK_HZ/SCAN_HZ cycles.
- BLANK_CYCLES, 100, cycles at the start of each slot during which all anodes are off. Requires 1 <= BLANK_CYCLES <= DIV-2; elaboration fails otherwise.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- en, input, 1, scan enable.
- digit_mask, input, 4, per-digit lit enable; bit i=1 allows digit i to light.
- sel, output, 2, digit select to mux_4_1.sel.
- an_n, output, 4, anode enables, active-low, at most one low at a time.
- blank, output, 1, high while in the BLANK state or while disabled.
- frame_tick, output, 1, one-cycle pulse when sel wraps from 3 to 0.

Behaviour:
- Reset (async assert, sync release): sel=0, an_n=4'b1111, blank=1, frame_tick=0, state=BLANK, slot counter cnt=0.
- All outputs are registered; no combinational path from inputs to outputs.
- cnt counts 0..DIV-1 while en=1. At cnt=DIV-1, cnt wraps to 0 and sel increments mod 4 on the same edge (3 -> 0 wraps).
- State BLANK (cnt < BLANK_CYCLES):
  - an_n=4'b1111, blank=1.
  - sel already holds the new digit, so mux data settles before lighting.
- State SHOW (BLANK_CYCLES <= cnt <= DIV-1):
  - blank=0.
  - an_n[sel]=0 only if digit_mask[sel]=1; all other bits are 1.
- Transitions:
  - BLANK -> SHOW when cnt reaches BLANK_CYCLES-1.
  - SHOW -> BLANK at cnt=DIV-1, together with the sel increment.
- frame_tick=1 for exactly the one cycle following the edge where sel goes 3 -> 0; otherwise 0.
- en=0:
  - Next edge forces state=BLANK, an_n=4'b1111, blank=1, cnt=0; sel holds; no frame_tick.
  - When en returns to 1, a full BLANK phase runs on the held sel before SHOW.
- en dropping exactly at cnt=DIV-1: disable wins; sel does not increment.
- digit_mask changes take effect on the next registered an_n update, including mid-SHOW. Clearing the active bit turns its anode off one cycle later, with no glitch.
- Reset asserted mid-slot: outputs go to reset values immediately, independent of clk.
- Width rule: cnt width = $clog2(DIV). Compare against DIV-1; no reliance on natural overflow.

Decomposition:
- Shared package seg_scan_pkg:
  - state enum {BLANK, SHOW}
  - constants NUM_DIGITS=4, SEL_W=2
  - localparam-style helper for the DIV computation
- One sub-module, slot_timer:
  - parameterised modulo-DIV counter with clear and enable
  - outputs cnt and a wrap pulse
- The FSM, sel counter and anode decode stay in seg_scan_ctrl.

Test Plan (all tests use CLK_HZ=1000, SCAN_HZ=100 so DIV=10, with BLANK_CYCLES=2):
1. Reset release with en=1, digit_mask=4'b1111 -> cycles 0-1 an_n=1111, blank=1. Cycles 2-9 an_n=1110, sel=0. Cycle 10 sel=1, an_n=1111. Cycle 12 an_n=1101.
2. Run 40 cycles -> sel sequence 0,1,2,3,0. frame_tick high exactly one cycle, at cycle 40. Never more than one an_n bit low.
3. digit_mask=4'b1011 -> during sel=2 the SHOW phase keeps an_n=1111 while blank=0. Other digits light normally.
4. Drop en at cnt=5 of sel=1 for 7 cycles, then re-assert -> an_n=1111 next cycle and sel stays 1. After re-enable, 2 blank cycles, then an_n=1101 for 8 cycles.
5. Assert rst_n=0 asynchronously mid-SHOW of sel=3 -> an_n=1111, sel=0, blank=1 before the next clk edge. frame_tick=0.
6. Connect to mux_4_1 with data=4'b1010 -> mux Y equals data[sel] throughout each SHOW window; Y transitions only inside BLANK windows.
